systolic_tile: RTL
==================

SYSTOLIC_TILE -- requirements
Module: systolic_tile

Interface
REQ-001 Parameter DIM, 4, array dimension (rows = columns), legal 2..16.
REQ-002 Parameter DATA_W, 8, activation/weight element width.
REQ-003 Parameter ACC_W, 20, result element width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at bank swap.
REQ-008 w_valid / w_ready  in / out  1 / 1  weight-row handshake.
REQ-009 w_row  in  DIM*DATA_W  one weight row W[r][0..DIM-1], element j at bits [j*DATA_W +: DATA_W].
REQ-010 w_last  in  1  marks the final (DIM-th) row of a weight matrix.
REQ-011 a_valid / a_ready  in / out  1 / 1  activation-vector handshake.
REQ-012 a_data  in  DIM*DATA_W  activation vector a[0..DIM-1].
REQ-013 a_last  in  1  marks the final vector of a batch.
REQ-014 y_valid  out  1  result valid; no backpressure, sink must accept.
REQ-015 y_data  out  DIM*ACC_W  result y[j] at bits [j*ACC_W +: ACC_W].
REQ-016 y_last  out  1  result belongs to the a_last vector.
REQ-017 busy  out  1  high in RUN or DRAIN.
REQ-018 err_wlast  out  1  sticky: w_last on a row other than the DIM-th.

Function
REQ-019 Result SHALL be y[j] = sum over i of a[i]*W[i][j], using the active weight bank.
REQ-020 Products sign-extended (signed_mode=1) or zero-extended (0) to ACC_W; sum wraps modulo 2^ACC_W, no saturation.
REQ-021 Two weight banks: active (used by the array) and shadow (filled by w_* port).
REQ-022 w_ready = 1 while shadow row count < DIM; accepted row r writes shadow row r, count increments; count = DIM -> shadow full, w_ready = 0.
REQ-023 Accepted w_last with count != DIM-1 -> err_wlast = 1 (sticky until reset); fullness decided by count only.
REQ-024 Compute FSM states IDLE, RUN, DRAIN; reset -> IDLE.
REQ-025 IDLE: a_ready = 0; shadow full -> swap, go RUN.
REQ-026 Swap (single cycle): active <= shadow, active signedness <= signed_mode, shadow count <= 0; w_ready returns 1 the cycle after the swap.
REQ-027 RUN: a_ready = 1; one vector accepted per cycle when a_valid; accepted a_last -> DRAIN, drain counter <= 2*DIM.
REQ-028 DRAIN: a_ready = 0; counter decrements each cycle; at 0 -> swap if shadow full, then RUN (else RUN reusing current active weights).
REQ-029 Latency: vector accepted at cycle t -> y_valid = 1 with its result at cycle t+2*DIM, exactly; input bubbles reproduced identically at output; throughput 1 vector/cycle.
REQ-030 y_last = 1 exactly with the result of the a_last vector; y_data = 0 whenever y_valid = 0.
REQ-031 Weight writes never affect in-flight vectors; active bank changes only in a swap, with no vector in flight.

Reset
REQ-032 Reset values: a_ready 0, w_ready 1, y_valid 0, y_data 0, y_last 0, busy 0, err_wlast 0; FSM IDLE, shadow count 0, active bank invalid.
REQ-033 Reset mid-operation discards all in-flight vectors and partial weights; no y_valid after reset until new vectors are accepted.

Verification
REQ-034 Reset, then hold a_valid=1 without weights -> a_ready stays 0; load 4 rows (DIM=4) -> w_ready falls after row 4, swap, a_ready=1 the next cycle.
REQ-035 W=identity, a=[1,2,3,4] with a_last accepted at t -> y=[1,2,3,4], y_valid and y_last at t+8; a_ready low for 8 cycles, then 1.
REQ-036 Unsigned, W all 0xFF, a all 0xFF -> every y[j] = 260100; signed, W all 0x80, a all 0x80 -> 65536; signed, a all 0xFF, W all 0x01 -> 0xFFFFC (-4).
REQ-037 Stream 3 vectors with W1 while loading W2 (w_ready 0 after 4th row); a_last -> drain -> swap; 4th vector uses W2, first 3 results use W1.
REQ-038 Reset with 3 vectors in flight -> y_valid stays 0; w_last on row 2 -> err_wlast = 1 and w_ready stays 1 until 4 rows are accepted.

Source files
------------

// File: rtl/systolic_tile.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_tile
//  Purpose  : DIM x DIM weight-stationary matrix-vector tile. Computes
//             y[j] = sum_i a[i]*W[i][j] with double-buffered weight banks,
//             a fixed 2*DIM cycle result latency and one vector per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_tile #(
  parameter int DIM    = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    signed_mode,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DIM*DATA_W-1:0]   w_row,
  input  logic                    w_last,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DIM*DATA_W-1:0]   a_data,
  input  logic                    a_last,
  output logic                    y_valid,
  output logic [DIM*ACC_W-1:0]    y_data,
  output logic                    y_last,
  output logic                    busy,
  output logic                    err_wlast
);

  localparam int DEPTH = 2 * DIM;
  localparam int ROW_W = DIM * DATA_W;
  localparam int VEC_W = DIM * ACC_W;
  localparam int CNT_W = $clog2(DIM + 1);
  localparam int DRN_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // control state
  state_t             state_q, state_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               a_ready_q, a_ready_d;
  logic               w_ready_q, w_ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  // weight banks
  logic [ROW_W-1:0]   shadow_q [DIM];
  logic [ROW_W-1:0]   shadow_d [DIM];
  logic [ROW_W-1:0]   active_q [DIM];
  logic [ROW_W-1:0]   active_d [DIM];
  logic               act_sgn_q, act_sgn_d;

  // datapath pipeline: stages 0..DIM-1 accumulate one row each, the rest delay
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   last_q, last_d;
  logic [VEC_W-1:0]   acc_q [DEPTH];
  logic [VEC_W-1:0]   acc_d [DEPTH];
  logic [ROW_W-1:0]   act_q [DIM-1];
  logic [ROW_W-1:0]   act_d [DIM-1];

  logic               a_fire;
  logic               w_fire;
  logic               shadow_full;
  logic               swap;

  // Extending both operands to ACC_W before multiplying gives the extended
  // product modulo 2^ACC_W, which is exactly the wrap-around sum term needed.
  function automatic logic [ACC_W-1:0] mul_ext(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] w,
    input logic              sgn
  );
    logic [ACC_W-1:0] ex;
    logic [ACC_W-1:0] ew;
    ex = {{(ACC_W-DATA_W){sgn & x[DATA_W-1]}}, x};
    ew = {{(ACC_W-DATA_W){sgn & w[DATA_W-1]}}, w};
    return ex * ew;
  endfunction

  assign a_fire      = a_valid & a_ready_q;
  assign w_fire      = w_valid & w_ready_q;
  assign shadow_full = (wcnt_q == CNT_W'(DIM));

  // Compute FSM: decides swaps and when activations may enter the array
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    swap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (shadow_full) begin
          swap    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (a_fire && a_last) begin
          state_d = S_DRAIN;
          drain_d = DRN_W'(DEPTH);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRN_W'(1);
        // counter reaches zero at this edge: the last vector has left the
        // multiply stages, so the active bank can be replaced safely
        if (drain_q == DRN_W'(1)) begin
          state_d = S_RUN;
          swap    = shadow_full;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Weight port, bank swap and registered handshake/status outputs
  always_comb begin
    shadow_d = shadow_q;
    for (int r = 0; r < DIM; r++) begin
      if (w_fire && (wcnt_q == CNT_W'(r))) begin
        shadow_d[r] = w_row;
      end
    end
    if (swap) begin
      wcnt_d = '0;
    end else if (w_fire) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
    err_d     = err_q | (w_fire & w_last & (wcnt_q != CNT_W'(DIM - 1)));
    active_d  = swap ? shadow_q : active_q;
    act_sgn_d = swap ? signed_mode : act_sgn_q;
    a_ready_d = (state_d == S_RUN);
    w_ready_d = (wcnt_d != CNT_W'(DIM));
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // Datapath: row k of the active bank is applied in stage k, then a plain
  // delay line pads the latency to 2*DIM; idle slots carry zeros
  always_comb begin
    vld_d  = {vld_q[DEPTH-2:0], a_fire};
    last_d = {last_q[DEPTH-2:0], a_fire & a_last};
    act_d[0] = a_fire ? a_data : '0;
    for (int k = 1; k < DIM - 1; k++) begin
      act_d[k] = act_q[k-1];
    end
    acc_d[0] = '0;
    for (int j = 0; j < DIM; j++) begin
      acc_d[0][j*ACC_W +: ACC_W] = mul_ext(act_d[0][0 +: DATA_W],
                                           active_q[0][j*DATA_W +: DATA_W],
                                           act_sgn_q);
    end
    for (int k = 1; k < DIM; k++) begin
      acc_d[k] = '0;
      for (int j = 0; j < DIM; j++) begin
        acc_d[k][j*ACC_W +: ACC_W] = acc_q[k-1][j*ACC_W +: ACC_W]
                                   + mul_ext(act_q[k-1][k*DATA_W +: DATA_W],
                                             active_q[k][j*DATA_W +: DATA_W],
                                             act_sgn_q);
      end
    end
    for (int k = DIM; k < DEPTH; k++) begin
      acc_d[k] = acc_q[k-1];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      wcnt_q    <= '0;
      a_ready_q <= 1'b0;
      w_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      act_sgn_q <= 1'b0;
      vld_q     <= '0;
      last_q    <= '0;
      for (int r = 0; r < DIM; r++) begin
        shadow_q[r] <= '0;
        active_q[r] <= '0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        acc_q[k] <= '0;
      end
      for (int k = 0; k < DIM - 1; k++) begin
        act_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      wcnt_q    <= wcnt_d;
      a_ready_q <= a_ready_d;
      w_ready_q <= w_ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      act_sgn_q <= act_sgn_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      for (int r = 0; r < DIM; r++) begin
        shadow_q[r] <= shadow_d[r];
        active_q[r] <= active_d[r];
      end
      for (int k = 0; k < DEPTH; k++) begin
        acc_q[k] <= acc_d[k];
      end
      for (int k = 0; k < DIM - 1; k++) begin
        act_q[k] <= act_d[k];
      end
    end
  end

  assign a_ready   = a_ready_q;
  assign w_ready   = w_ready_q;
  assign busy      = busy_q;
  assign err_wlast = err_q;
  assign y_valid   = vld_q[DEPTH-1];
  assign y_last    = last_q[DEPTH-1];
  assign y_data    = acc_q[DEPTH-1];

endmodule
`default_nettype wire
